// File: rtl/serial_to_parallel_converter.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel_converter
// Function : Reassembles LSB-first serial frames into DATA_W-bit words and
//            queues them in a small FIFO with a valid/ready output. Flags
//            words dropped on a full FIFO and frames broken by a valid gap.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel_converter #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_i,
  input  logic                       valid_i,
  output logic [DATA_W-1:0]          parallel_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic                       overflow_o,
  output logic                       frame_err_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int FCW   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W-1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] word;
  logic              push;
  logic              abort;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     count;
  logic              full, empty, pop, wr_en, drop;

  // Assembly FSM next-state: places each valid bit at bit_cnt, completes on the last bit
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    word        = shreg;
    word[bit_cnt] = serial_i;
    push        = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) begin
          shreg_nxt   = word;
          bit_cnt_nxt = CNT_W'(1);
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (valid_i) begin
          if (bit_cnt == LAST_BIT) begin
            // Word complete: hand it to the FIFO and be ready for a back-to-back frame
            push        = 1'b1;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            shreg_nxt   = word;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end else begin
          // Valid gap inside a frame: drop the partial word
          abort       = 1'b1;
          shreg_nxt   = '0;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
        shreg_nxt   = '0;
      end
    endcase
  end

  // Assembly FSM state, bit counter and partial-word registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // FIFO status; a pop on a full FIFO frees the slot for a same-cycle push
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == PW'(DEPTH));
  assign empty        = (count == '0);
  assign pop          = !empty && out_ready_i;
  assign wr_en        = push && (!full || pop);
  assign drop         = push && full && !pop;
  assign out_valid_o  = !empty;
  assign fifo_count_o = FCW'(count);
  assign parallel_o   = mem[rd_ptr[AW-1:0]];

  // FIFO storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= word;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Single-cycle error pulses, raised the cycle after the event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      overflow_o  <= drop;
      frame_err_o <= abort;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel_converter
// Function : Directed, table-driven bench for serial_to_parallel_converter
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel_converter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [3:0] parallel_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [2:0] fifo_count_o;
  logic       overflow_o;
  logic       frame_err_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] seq;  // bits in send order: seq[3] first, seq[0] last
    logic [3:0] exp;  // hand-computed reassembled word
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] drain_exp [4];

  serial_to_parallel_converter #(.DATA_W(4), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_i     (serial_i),
    .valid_i      (valid_i),
    .parallel_o   (parallel_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends a word LSB first, leaving valid_i high afterwards
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      serial_i = w[i];
      valid_i  = 1'b1;
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{seq: 4'b1011, exp: 4'b1101};
    vecs[1] = '{seq: 4'b0101, exp: 4'b1010};
    vecs[2] = '{seq: 4'b1100, exp: 4'b0011};
    vecs[3] = '{seq: 4'b1111, exp: 4'b1111};
    vecs[4] = '{seq: 4'b1000, exp: 4'b0001};
    vecs[5] = '{seq: 4'b0001, exp: 4'b1000};
    vecs[6] = '{seq: 4'b1001, exp: 4'b1001};
    vecs[7] = '{seq: 4'b0110, exp: 4'b0110};
    drain_exp[0] = 4'h2; drain_exp[1] = 4'h3; drain_exp[2] = 4'h4; drain_exp[3] = 4'h6;

    // Reset state
    #2;
    check("rst_valid", out_valid_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_parallel", parallel_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_ferr", frame_err_o, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single frames, consumer always ready
    out_ready_i = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int b = 3; b >= 0; b--) begin
        serial_i = vecs[v].seq[b];
        valid_i  = 1'b1;
        tick();
        if (b == 1) check("vec_early_valid", out_valid_o, 0);
      end
      valid_i = 1'b0;
      check("vec_valid", out_valid_o, 1);
      check("vec_word", parallel_o, vecs[v].exp);
      check("vec_count1", fifo_count_o, 1);
      tick();
      check("vec_count0", fifo_count_o, 0);
    end
    out_ready_i = 1'b0;

    // Back-to-back frames queued, then drained in order
    send_word(4'hA);
    send_word(4'h3);
    send_word(4'hF);
    valid_i = 1'b0;
    check("b2b_count", fifo_count_o, 3);
    out_ready_i = 1'b1;
    check("b2b_head0", parallel_o, 4'hA);
    tick();
    check("b2b_head1", parallel_o, 4'h3);
    tick();
    check("b2b_head2", parallel_o, 4'hF);
    tick();
    check("b2b_empty", fifo_count_o, 0);
    out_ready_i = 1'b0;

    // Overflow: fifth word dropped; sixth accepted thanks to same-cycle pop
    for (int f = 1; f <= 4; f++) send_word(4'(f));
    check("ovf_nopulse", overflow_o, 0);
    send_word(4'h5);
    check("ovf_pulse", overflow_o, 1);
    check("ovf_count", fifo_count_o, 4);
    check("ovf_head", parallel_o, 4'h1);
    valid_i = 1'b0;
    tick();
    check("ovf_single", overflow_o, 0);
    for (int i = 0; i < 3; i++) begin
      serial_i = i[0] ? 1'b1 : 1'b0;  // word 6 = 4'b0110, LSB first: 0,1,1,0
      serial_i = (i == 0) ? 1'b0 : 1'b1;
      valid_i  = 1'b1;
      tick();
    end
    serial_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    valid_i = 1'b0;
    check("full_pp_count", fifo_count_o, 4);
    check("full_pp_head", parallel_o, 4'h2);
    tick();
    check("full_pp_noovf", overflow_o, 0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain", parallel_o, drain_exp[i]);
      tick();
    end
    out_ready_i = 1'b0;
    check("ovf_drained", fifo_count_o, 0);

    // Frame error: two bits, gap, then a clean frame
    serial_i = 1'b1;
    valid_i  = 1'b1;
    tick();
    tick();
    valid_i = 1'b0;
    tick();
    check("ferr_pulse", frame_err_o, 1);
    check("ferr_count", fifo_count_o, 0);
    send_word(4'h5);
    valid_i = 1'b0;
    check("ferr_single", frame_err_o, 0);
    check("ferr_count1", fifo_count_o, 1);
    check("ferr_word", parallel_o, 4'h5);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("ferr_drained", fifo_count_o, 0);

    // Asynchronous reset mid-frame with two words queued
    send_word(4'h7);
    send_word(4'h8);
    serial_i = 1'b1;
    valid_i  = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_count", fifo_count_o, 0);
    valid_i = 1'b0;
    #1 reset = 1'b0;
    tick();
    send_word(4'h9);
    valid_i = 1'b0;
    check("arst_word", parallel_o, 4'h9);
    check("arst_count1", fifo_count_o, 1);
    check("arst_noerr", {overflow_o, frame_err_o}, 0);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;

    // Twelve frames with random consumer readiness, scoreboarded
    begin
      int model_cnt;
      int exp_idx;
      logic pop;
      model_cnt = 0;
      exp_idx   = 0;
      for (int f = 0; f < 12; f++) begin
        for (int b = 0; b < 4; b++) begin
          serial_i = f[b];
          valid_i  = 1'b1;
          out_ready_i = (model_cnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          check("rnd_valid", out_valid_o, (model_cnt > 0) ? 1 : 0);
          pop = (model_cnt > 0) && out_ready_i;
          if (pop) begin
            check("rnd_order", parallel_o, exp_idx);
            exp_idx++;
          end
          tick();
          model_cnt = model_cnt + ((b == 3) ? 1 : 0) - (pop ? 1 : 0);
          check("rnd_count", fifo_count_o, model_cnt);
        end
      end
      valid_i = 1'b0;
      out_ready_i = 1'b1;
      for (int k = 0; k < 8 && model_cnt > 0; k++) begin
        check("rnd_drain", parallel_o, exp_idx);
        exp_idx++;
        tick();
        model_cnt--;
      end
      out_ready_i = 1'b0;
      check("rnd_total", exp_idx, 12);
      check("rnd_empty", fifo_count_o, 0);
      check("rnd_noovf", overflow_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
